// File: rtl/disp_pkg.sv
// Shared definitions for the BCD display converter: FSM states and display limits.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned MAX_DISP   = 9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
  end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Define BCD_SAT_EN to clamp displayed digits to 9999 on overflow.
module bcd_converter
  import disp_pkg::*;
#(
  parameter int unsigned BIN_W = 16
) (
  input  logic             clk_i,
  input  logic             porb_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_data_i,
  output logic [3:0]       bcd_digits_o [NUM_DIGITS-1:0],
  output logic             done_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int unsigned SCR_DIGITS = NUM_DIGITS + 1;
  localparam logic [4:0]  LAST_ITER  = 5'(BIN_W);

  state_t                    state_q, state_d;
  logic [BIN_W-1:0]          shreg_q;
  logic [4*SCR_DIGITS-1:0]   scratch_q;
  logic [4*SCR_DIGITS-1:0]   scratch_adj;
  logic [4:0]                iter_q;
  logic                      last_iter;
  logic                      scr_ovf;
  logic [3:0]                result_d [NUM_DIGITS-1:0];

  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch_q[4*g +: 4]),
      .digit_out (scratch_adj[4*g +: 4])
    );
  end

  assign last_iter = (iter_q == LAST_ITER);
  assign busy_o    = (state_q != ST_IDLE);
  // The adjuster maps zero to zero and any legal nonzero digit to nonzero,
  // so the adjusted top digit is an equivalent overflow test.
  assign scr_ovf   = (scratch_adj[4*SCR_DIGITS-1 -: 4] != '0);

  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            shreg_q   <= bin_data_i;
            scratch_q <= '0;
            iter_q    <= '0;
          end
        end
        ST_SHIFT: begin
          if (!last_iter) begin
            scratch_q <= {scratch_adj[4*SCR_DIGITS-2:0], shreg_q[BIN_W-1]};
            shreg_q   <= shreg_q << 1;
            iter_q    <= iter_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      result_d[i] = scratch_q[4*(NUM_DIGITS-1-i) +: 4];
    end
`ifdef BCD_SAT_EN
    if (scr_ovf) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) result_d[i] = 4'd9;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      done_o       <= 1'b0;
      ovf_o        <= 1'b0;
      bcd_digits_o <= '{default: '0};
    end else begin
      done_o <= (state_q == ST_SHIFT) && last_iter;
      if ((state_q == ST_SHIFT) && last_iter) begin
        ovf_o        <= scr_ovf;
        bcd_digits_o <= result_d;
      end
    end
  end

endmodule
